// File: rtl/sync_ram_sdp.sv
// sync_ram_sdp: parametrised simple-dual-port RAM with a zeroing clear engine and rd_valid qualifier.
// Define SYNC_RAM_OREG_EN to add an output register stage (2-cycle read latency).
module sync_ram_sdp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              ready,
  output logic              req_drop
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_ptr, ptr_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic accept, wr_acc, rd_acc, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd_data;
  assign ready = state == READY;
  always_comb begin
    state_n   = clr ? CLEAR : (state == CLEAR && &clr_ptr) ? READY : state;
    ptr_n     = (clr || state == READY) ? '0 : clr_ptr + ADDR_W'(1);
    accept    = ready && !clr;
    wr_acc    = we && accept;
    rd_acc    = re && accept;
    mem_we    = state == CLEAR || wr_acc;
    mem_waddr = state == CLEAR ? clr_ptr : waddr;
    mem_wdata = state == CLEAR ? '0 : din;
    rd_data   = (wr_acc && waddr == raddr) ? din : mem[raddr];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      req_drop <= 1'b0;
    end else begin
      state    <= state_n;
      clr_ptr  <= ptr_n;
      req_drop <= (we || re) && !accept;
    end
  // Contents are deliberately not reset; the clear sweep zeroes them.
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef SYNC_RAM_OREG_EN
  logic [DATA_W-1:0] d1;
  logic v1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1       <= '0;
      v1       <= 1'b0;
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      v1       <= rd_acc;
      if (rd_acc) d1 <= rd_data;
      rd_valid <= v1 && !clr;
      if (v1 && !clr) dout <= d1;
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) dout <= rd_data;
    end
`endif
endmodule
